// File: rtl/pwm_frame_sequencer.sv
// Frame sequencer for the PWM array: shadow buffer, latch loader, period counter.
// Define PWM_SEQ_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module pwm_frame_sequencer #(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8,
  localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1,
  localparam int FW = $clog2(STAGE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              lat_valid,
  output logic [IW-1:0]     lat_idx,
  output logic [DWIDTH-1:0] lat_data,
  output logic              cnt_rst,
  output logic [DWIDTH-1:0] count,
  output logic              hsync,
  output logic              busy,
  output logic              underrun,
  input  logic              clr_underrun
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              pend_q, pend_d;
  logic              urun_q, urun_d;
  logic              take;
  logic              last_load;
  logic              per_end;
  logic              urun_set;
  logic [DWIDTH-1:0] mem_q [STAGE];

  assign in_ready  = !pend_q && (state_q != LOAD) && !rst;
  assign take      = in_valid && in_ready;
  assign last_load = (state_q == LOAD) && (idx_q == IW'(STAGE - 1));
  assign per_end   = (state_q == RUN) && (&count_q);
  assign urun_set  = per_end && enable && !pend_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        idx_d   = '0;
        if (enable && pend_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = '0;
        idx_d   = idx_q + 1'b1;
        if (last_load) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        count_d = count_q + 1'b1;
        if (per_end) begin
          if (!enable) begin
            state_d = IDLE;
            count_d = '0;
          end else if (pend_q) begin
            state_d = LOAD;
            count_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loading consumes the pending frame, so it overrides a fill update.
  always_comb begin
    fill_d = fill_q;
    pend_d = pend_q;
    if (take) begin
      fill_d = fill_q + 1'b1;
      if (fill_q == FW'(STAGE - 1)) pend_d = 1'b1;
    end
    if (last_load) begin
      fill_d = '0;
      pend_d = 1'b0;
    end
    urun_d = urun_q;
    if (urun_set) urun_d = 1'b1;
    else if (clr_underrun) urun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      urun_q  <= urun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take) mem_q[fill_q[IW-1:0]] <= in_data;
  end

  assign lat_valid = (state_q == LOAD);
  assign lat_idx   = idx_q;
  assign lat_data  = lat_valid ? mem_q[idx_q] : '0;
  assign cnt_rst   = (state_q != RUN);
  assign count     = count_q;
  assign hsync     = (state_q == RUN) && (count_q == '0);
  assign busy      = (state_q != IDLE);
  assign underrun  = urun_q;

`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (urun_set) begin
      if (clr_underrun) ucnt_d = 16'd1;
      else if (!(&ucnt_q)) ucnt_d = ucnt_q + 16'd1;
    end else if (clr_underrun) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Directed bench for pwm_frame_sequencer at DWIDTH=4, STAGE=4.
// Define PWM_SEQ_UNDERRUN_CNT_EN to also exercise underrun_cnt.
module tb_pwm_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       lat_valid;
  logic [1:0] lat_idx;
  logic [3:0] lat_data;
  logic       cnt_rst;
  logic [3:0] count;
  logic       hsync;
  logic       busy;
  logic       underrun;
  logic       clr_underrun;
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pwm_frame_sequencer #(.DWIDTH(4), .STAGE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .lat_valid    (lat_valid),
    .lat_idx      (lat_idx),
    .lat_data     (lat_data),
    .cnt_rst      (cnt_rst),
    .count        (count),
    .hsync        (hsync),
    .busy         (busy),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int tgt);
    int n;
    n = 0;
    while (count !== 4'(tgt) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (count !== 4'(tgt)) begin
      errors++;
      $display("FAIL run_to count got %0d exp %0d", count, tgt);
    end
  endtask

  task automatic push4(input logic [3:0] a, b, c, d);
    logic [3:0] w [4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL push_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b exp 0", in_ready);
    end
  endtask

  task automatic check_load(input logic [3:0] a, b, c, d);
    logic [3:0] w [4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lat_valid !== 1'b1 || lat_idx !== 2'(i) || lat_data !== w[i]) begin
        errors++;
        $display("FAIL load[%0d] got v=%b idx=%0d d=%0d exp v=1 idx=%0d d=%0d",
                 i, lat_valid, lat_idx, lat_data, i, w[i]);
      end
      checks++;
      if (cnt_rst !== 1'b1 || count !== 4'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_ctl[%0d] got crst=%b cnt=%0d rdy=%b exp 1 0 0",
                 i, cnt_rst, count, in_ready);
      end
      tick();
    end
    checks++;
    if (lat_valid !== 1'b0 || cnt_rst !== 1'b0 || count !== 4'd0 || hsync !== 1'b1) begin
      errors++;
      $display("FAIL run_start got v=%b crst=%b cnt=%0d hs=%b exp 0 0 0 1",
               lat_valid, cnt_rst, count, hsync);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clr_underrun = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || lat_valid !== 1'b0 || lat_idx !== 2'd0 || lat_data !== 4'd0) begin
      errors++;
      $display("FAIL reset_lat got rdy=%b v=%b idx=%0d d=%0d exp 0 0 0 0",
               in_ready, lat_valid, lat_idx, lat_data);
    end
    checks++;
    if (cnt_rst !== 1'b1 || count !== 4'd0 || hsync !== 1'b0 ||
        busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got crst=%b cnt=%0d hs=%b busy=%b ur=%b exp 1 0 0 0 0",
               cnt_rst, count, hsync, busy, underrun);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_load();
    push4(4'd3, 4'd7, 4'd0, 4'd15);
    tick();
    checks++;
    if (busy !== 1'b0 || lat_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b v=%b exp 0 0", busy, lat_valid);
    end
    enable = 1'b1;
    tick();
    check_load(4'd3, 4'd7, 4'd0, 4'd15);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_ready got rdy=%b busy=%b exp 1 1", in_ready, busy);
    end
    tick();
    checks++;
    if (count !== 4'd1 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL run_cnt1 got cnt=%0d hs=%b exp 1 0", count, hsync);
    end
  endtask

  task automatic test_back_to_back();
    push4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL b2b_cnt got %0d exp 5", count);
    end
    run_to(15);
    checks++;
    if (hsync !== 1'b0 || underrun !== 1'b0 || lat_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got hs=%b ur=%b v=%b exp 0 0 0", hsync, underrun, lat_valid);
    end
    tick();
    check_load(4'd1, 4'd2, 4'd3, 4'd4);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_underrun got %b exp 0", underrun);
    end
  endtask

  task automatic test_starve();
    run_to(15);
    tick();
    checks++;
    if (busy !== 1'b1 || lat_valid !== 1'b0 || count !== 4'd0 ||
        hsync !== 1'b1 || cnt_rst !== 1'b0 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL starve got busy=%b v=%b cnt=%0d hs=%b crst=%b ur=%b exp 1 0 0 1 0 1",
               busy, lat_valid, count, hsync, cnt_rst, underrun);
    end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_underrun got %b exp 0", underrun);
    end
    run_to(15);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL set_wins got ur=%b cnt=%0d exp 1 0", underrun, count);
    end
  endtask

  task automatic test_disable();
    run_to(1);
    push4(4'd5, 4'd6, 4'd7, 4'd8);
    enable = 1'b0;
    run_to(15);
    checks++;
    if (busy !== 1'b1 || cnt_rst !== 1'b0) begin
      errors++;
      $display("FAIL dis_full_period got busy=%b crst=%b exp 1 0", busy, cnt_rst);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_rst !== 1'b1 || count !== 4'd0 ||
        lat_valid !== 1'b0 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL dis_idle got busy=%b crst=%b cnt=%0d v=%b hs=%b exp 0 1 0 0 0",
               busy, cnt_rst, count, lat_valid, hsync);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || lat_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dis_hold got busy=%b v=%b rdy=%b exp 0 0 0", busy, lat_valid, in_ready);
    end
  endtask

  task automatic test_rst_load();
    enable = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (lat_valid !== 1'b1 || lat_idx !== 2'd2 || lat_data !== 4'd7) begin
      errors++;
      $display("FAIL pre_rst_load got v=%b idx=%0d d=%0d exp 1 2 7", lat_valid, lat_idx, lat_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (lat_valid !== 1'b0 || lat_idx !== 2'd0 || lat_data !== 4'd0 || in_ready !== 1'b0 ||
        cnt_rst !== 1'b1 || count !== 4'd0 || hsync !== 1'b0 || busy !== 1'b0 ||
        underrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got v=%b idx=%0d d=%0d rdy=%b crst=%b cnt=%0d hs=%b busy=%b ur=%b",
               lat_valid, lat_idx, lat_data, in_ready, cnt_rst, count, hsync, busy, underrun);
    end
    rst = 1'b0;
    #1;
    push4(4'd10, 4'd11, 4'd12, 4'd13);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle got busy=%b exp 0", busy);
    end
    tick();
    check_load(4'd10, 4'd11, 4'd12, 4'd13);
  endtask

`ifdef PWM_SEQ_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ucnt_clr got %0d exp 0", underrun_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      run_to(15);
      tick();
    end
    checks++;
    if (underrun_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ucnt_3 got %0d exp 3", underrun_cnt);
    end
    dut.ucnt_q = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_to(15);
      tick();
    end
    checks++;
    if (underrun_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL ucnt_sat got %h exp ffff", underrun_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_starve();
    test_disable();
    test_rst_load();
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_frame_sequencer.md
Name: pwm_frame_sequencer

Overview:
- Controller that sequences the multi-channel PWM array.
- Accepts STAGE duty words per frame over a valid/ready stream into a shadow buffer.
- At PWM period boundaries, streams the frame into the per-channel data latch.
- Owns the period counter, the counter reset and the hsync pulse, so the PWM blocks only compare data against count.

Parameters:
- DWIDTH, 8, duty/counter width; one PWM period = 2^DWIDTH clk cycles.
- STAGE, 8, number of PWM channels (words per frame).

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run request; sampled at IDLE and at every period end.
- in_valid  input  1  duty word valid.
- in_ready  output  1  shadow buffer can accept a word.
- in_data  input  DWIDTH  duty word; words arrive in channel order 0..STAGE-1.
- lat_valid  output  1  lat_data/lat_idx valid this cycle.
- lat_idx  output  $clog2(STAGE) (min 1)  channel index being loaded.
- lat_data  output  DWIDTH  duty value for channel lat_idx.
- cnt_rst  output  1  holds PWM counter/blocks in reset.
- count  output  DWIDTH  period counter, shared by all PWM blocks.
- hsync  output  1  one-cycle pulse on the first cycle of each period.
- busy  output  1  state != IDLE.
- underrun  output  1  sticky: a period ended with enable=1 and no new frame pending.
- clr_underrun  input  1  clears underrun.

Behaviour:
- Reset values: in_ready=0, lat_valid=0, lat_idx=0, lat_data=0, cnt_rst=1, count=0, hsync=0, busy=0, underrun=0.
  - Reset clears fill_cnt, frame_pending and the state (IDLE). Buffer contents are don't-care.
  - Reset mid-LOAD or mid-RUN aborts immediately; the next cycle shows reset values.
- Shadow buffer: STAGE x DWIDTH entries, fill_cnt 0..STAGE.
  - in_ready = !frame_pending && state != LOAD && !rst.
  - A word is taken when in_valid && in_ready and written to entry fill_cnt.
  - When fill_cnt reaches STAGE, frame_pending=1.
  - Words beyond a full frame are not accepted (in_ready=0).
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - cnt_rst=1, count=0.
  - If enable && frame_pending, go to LOAD next cycle.
- LOAD:
  - Lasts exactly STAGE cycles, lat_valid=1, lat_idx=0..STAGE-1, lat_data=buffer[lat_idx].
  - cnt_rst=1, count held at 0.
  - On the last LOAD cycle, clear frame_pending and fill_cnt; in_ready rises the next cycle.
  - Then go to RUN.
- RUN:
  - cnt_rst=0; count increments by 1 each cycle from 0 and wraps modulo 2^DWIDTH.
  - hsync=1 only in cycles where count==0.
  - Period end is the cycle with count==2^DWIDTH-1. At period end:
    - frame_pending && enable -> LOAD.
    - !frame_pending && enable -> stay in RUN; count wraps to 0 and the active frame repeats. Set underrun.
    - !enable -> IDLE; count=0, cnt_rst=1 next cycle.
  - enable dropping mid-period has no effect until the period end (no truncated periods).
- Latency: with a full frame pending and enable=1 in IDLE:
  - LOAD starts the next cycle.
  - First hsync appears STAGE+1 cycles after the IDLE decision cycle.
- Simultaneous events:
  - Underrun set and clr_underrun in the same cycle -> set wins.
  - The last word arriving on the same cycle as a period end is not counted as pending for that boundary: frame_pending is registered, so an underrun is flagged.
- Widths: count is natural DWIDTH-bit wrap, no saturation. fill_cnt has $clog2(STAGE+1) bits.

Optional Feature:
- Macro: PWM_SEQ_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt [15:0], reset 0.
  - Increments by 1 on every underrun event and saturates at 16'hFFFF.
  - Cleared by clr_underrun; an increment in the same cycle wins, giving a value of 1.
- When undefined: the port and counter are absent; only the sticky underrun flag exists.

Test Plan:
- DWIDTH=4, STAGE=4; push 3,7,0,15, enable=1 -> 4 LOAD cycles with lat_idx 0..3 and lat_data 3,7,0,15; cnt_rst falls; hsync at count=0; next period starts 16 cycles later.
- Back-to-back frames: second frame 1,2,3,4 pushed during RUN -> in_ready=0 after the 4th word; at count=15, LOAD of 1,2,3,4, then a new period; underrun stays 0.
- Starvation: no second frame -> at count=15 the state stays RUN, count wraps to 0, hsync pulses, underrun=1; clr_underrun with no event -> 0; clr together with a new event -> stays 1.
- enable deasserted at count=5 -> period completes to 15, then IDLE; cnt_rst=1, count=0, busy=0; no LOAD although a frame is pending.
- rst asserted mid-LOAD (lat_idx=2) -> next cycle all outputs at reset values, fill_cnt=0; a fresh frame then loads from idx 0.
- With PWM_SEQ_UNDERRUN_CNT_EN: 3 starved periods -> underrun_cnt=3; preload 16'hFFFE plus 3 events -> saturates at 16'hFFFF.
